bsg_vanilla_remote_load_wb: RTL and testbench
=============================================

BSG_VANILLA_REMOTE_LOAD_WB -- requirements
Module: bsg_vanilla_remote_load_wb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter els_p, default 2, SHALL set the buffer depth in entries (minimum 2).
REQ-003 Parameter starve_limit_p, default 16, SHALL set the number of ungranted head-valid cycles before a pipeline stall request.
REQ-004 Port clk_i  in  1  SHALL be the clock.
REQ-005 Port reset_i  in  1  SHALL be the synchronous active-high reset.
REQ-006 Port resp_v_i  in  1  SHALL indicate a valid remote load response.
REQ-007 Port resp_i  in  remote_load_resp_s  SHALL carry float_wb, reg_id, is_unsigned_op, is_byte_op, is_hex_op, part_sel and data[31:0].
REQ-008 Port resp_ready_o  out  1  SHALL indicate that a response is accepted in this cycle when resp_v_i is also high.
REQ-009 Ports int_wb_v_o, int_wb_addr_o and int_wb_data_o  out  1/5/32  SHALL form the integer RF write request.
REQ-010 Port int_wb_yumi_i  in  1  SHALL indicate that the core granted the integer RF write port in this cycle.
REQ-011 Ports float_wb_v_o, float_wb_addr_o and float_wb_data_o  out  1/5/32  SHALL form the FP RF write request.
REQ-012 Port float_wb_yumi_i  in  1  SHALL indicate that the core granted the FP RF write port in this cycle.
REQ-013 Port stall_wb_o  out  1  SHALL request that the core bubble its own WB stage so the head entry can retire.

Function
REQ-014 Responses SHALL be accepted when resp_v_i and resp_ready_o are both high; resp_ready_o SHALL be high only when the buffer is not full, and it SHALL depend only on registered occupancy.
REQ-015 An accepted response SHALL appear at the outputs no earlier than the next cycle; there is no combinational input-to-output bypass.
REQ-016 Entries SHALL retire strictly in arrival order, and only the head entry is presented.
REQ-017 When the head has float_wb=1, float_wb_v_o SHALL be 1, int_wb_v_o SHALL be 0, and float_wb_data_o SHALL equal data unmodified.
REQ-018 When the head has float_wb=0, int_wb_v_o SHALL be 1 and float_wb_v_o SHALL be 0.
REQ-019 Byte alignment: for is_byte_op, the block SHALL select data[8*part_sel+7 : 8*part_sel], zero-extend it when is_unsigned_op=1, and sign-extend it otherwise.
REQ-020 Hex alignment: for is_hex_op, the block SHALL select data[16*part_sel[1]+15 : 16*part_sel[1]], zero-extend it when is_unsigned_op=1, and sign-extend it otherwise; part_sel[0] SHALL be ignored.
REQ-021 Word alignment: when neither is_byte_op nor is_hex_op is set, the integer data SHALL pass through unmodified.
REQ-022 Both wb_addr outputs SHALL equal the head reg_id.
REQ-023 The head SHALL dequeue in the cycle that the yumi matching its destination is high.
REQ-024 Enqueue and dequeue in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-025 A yumi asserted while the corresponding wb_v_o is 0 SHALL be illegal and SHALL be flagged by a simulation assertion.
REQ-026 The starve counter SHALL increment each cycle the head is valid and not dequeued, saturate at starve_limit_p, and clear on dequeue or when the buffer is empty.
REQ-027 stall_wb_o SHALL be high while the starve counter equals starve_limit_p, and SHALL fall in the cycle after the head dequeues.
REQ-028 Buffer states SHALL be EMPTY, PARTIAL and FULL; the block SHALL go EMPTY→PARTIAL on enqueue, PARTIAL→FULL on enqueue without dequeue, FULL→PARTIAL on dequeue, and PARTIAL→EMPTY on dequeue without enqueue.

Reset
REQ-029 While reset_i is high, int_wb_v_o, float_wb_v_o, stall_wb_o and the starve counter SHALL be 0 and the buffer SHALL be EMPTY; resp_ready_o SHALL be 0 during reset.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries, and no write SHALL be issued for them afterwards.
REQ-031 resp_ready_o SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 remote_load_resp_s SHALL remain in the vanilla shared package, and a new localparam for the default starve limit (value 16) SHALL be added there.
REQ-033 Buffering SHALL use one sub-module, bsg_fifo_1r1w_small; the alignment logic and starve counter SHALL be local to this block.

Verification
REQ-034 Byte signed: enqueue data=0x80FF_7F01, is_byte_op=1, part_sel=3, signed, reg_id=7 -> next cycle int_wb_v_o=1, int_wb_addr_o=7, int_wb_data_o=0xFFFF_FF80.
REQ-035 Hex unsigned: enqueue data=0x8001_1234, is_hex_op=1, part_sel=2, unsigned -> int_wb_data_o=0x0000_8001; with part_sel=1 -> 0x0000_1234.
REQ-036 Float: enqueue float_wb=1, reg_id=3, data=0x3F80_0000 -> float_wb_v_o=1, int_wb_v_o=0, float_wb_data_o=0x3F80_0000.
REQ-037 Full and order: enqueue 3 responses with both yumis low -> resp_ready_o=0 after 2 accepts; grant twice -> retirement in order A, B; the third response is accepted the cycle after the first dequeue.
REQ-038 Starvation: hold int_wb_yumi_i=0 with the head valid for 16 cycles -> stall_wb_o=1 on cycle 16; yumi -> stall_wb_o=0 on the next cycle.
REQ-039 Reset mid-operation: with 2 entries buffered, pulse reset_i -> no wb_v_o afterwards and resp_ready_o=1 after release.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types: remote load response layout and buffer state encoding.
package bsg_vanilla_pkg;

    localparam int unsigned reg_addr_width_lp     = 5;
    localparam int unsigned data_width_lp         = 32;
    localparam int unsigned starve_limit_default_lp = 16;

    typedef struct packed {
        logic                         float_wb;
        logic [reg_addr_width_lp-1:0] reg_id;
        logic                         is_unsigned_op;
        logic                         is_byte_op;
        logic                         is_hex_op;
        logic [1:0]                   part_sel;
        logic [data_width_lp-1:0]     data;
    } remote_load_resp_s;

    typedef enum logic [1:0] {
        FifoEmpty   = 2'd0,
        FifoPartial = 2'd1,
        FifoFull    = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO with valid/ready enqueue and valid/yumi dequeue.
module bsg_fifo_1r1w_small
    import bsg_vanilla_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned CntW = $clog2(els_p + 1);

    fifo_state_e         state_q, state_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [width_p-1:0]  mem_q [els_p];
    logic                enq, deq;

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= FifoEmpty;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by state_q.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FifoEmpty: begin
                if (enq) state_d = FifoPartial;
            end
            FifoPartial: begin
                if (enq && !deq && count_q == CntW'(els_p - 1)) begin
                    state_d = FifoFull;
                end else if (deq && !enq && count_q == CntW'(1)) begin
                    state_d = FifoEmpty;
                end
            end
            FifoFull: begin
                if (deq) state_d = FifoPartial;
            end
            default: state_d = FifoEmpty;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(els_p - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(els_p - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ready_o = ~reset_i & (state_q != FifoFull);
        v_o     = ~reset_i & (state_q != FifoEmpty);
        data_o  = mem_q[rd_ptr_q];
    end

    a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi_i && !v_o));

endmodule

// File: rtl/bsg_vanilla_remote_load_wb.sv
// Buffers remote load responses, aligns sub-word integer data and arbitrates for RF write ports.
module bsg_vanilla_remote_load_wb
    import bsg_vanilla_pkg::*;
#(
    parameter int unsigned els_p          = 2,
    parameter int unsigned starve_limit_p = starve_limit_default_lp
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         resp_v_i,
    input  remote_load_resp_s            resp_i,
    output logic                         resp_ready_o,

    output logic                         int_wb_v_o,
    output logic [reg_addr_width_lp-1:0] int_wb_addr_o,
    output logic [data_width_lp-1:0]     int_wb_data_o,
    input  logic                         int_wb_yumi_i,

    output logic                         float_wb_v_o,
    output logic [reg_addr_width_lp-1:0] float_wb_addr_o,
    output logic [data_width_lp-1:0]     float_wb_data_o,
    input  logic                         float_wb_yumi_i,

    output logic                         stall_wb_o
);

    localparam int unsigned StarveW = $clog2(starve_limit_p + 1);

    remote_load_resp_s   head;
    logic                head_v;
    logic                head_yumi;
    logic [7:0]          byte_sel;
    logic [15:0]         hex_sel;
    logic [StarveW-1:0]  starve_q, starve_d;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(remote_load_resp_s)),
        .els_p   (els_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (resp_v_i),
        .ready_o (resp_ready_o),
        .data_i  (resp_i),
        .v_o     (head_v),
        .data_o  (head),
        .yumi_i  (head_yumi)
    );

    assign head_yumi = (int_wb_v_o & int_wb_yumi_i) | (float_wb_v_o & float_wb_yumi_i);

    always_comb begin
        case (head.part_sel)
            2'd0:    byte_sel = head.data[7:0];
            2'd1:    byte_sel = head.data[15:8];
            2'd2:    byte_sel = head.data[23:16];
            default: byte_sel = head.data[31:24];
        endcase
        hex_sel = head.part_sel[1] ? head.data[31:16] : head.data[15:0];

        if (head.is_byte_op) begin
            int_wb_data_o = {{24{~head.is_unsigned_op & byte_sel[7]}}, byte_sel};
        end else if (head.is_hex_op) begin
            int_wb_data_o = {{16{~head.is_unsigned_op & hex_sel[15]}}, hex_sel};
        end else begin
            int_wb_data_o = head.data;
        end
    end

    always_comb begin
        int_wb_v_o      = head_v & ~head.float_wb;
        float_wb_v_o    = head_v &  head.float_wb;
        int_wb_addr_o   = head.reg_id;
        float_wb_addr_o = head.reg_id;
        float_wb_data_o = head.data;
    end

    // Count cycles the head waits for a port; saturates so stall holds until it retires.
    always_comb begin
        starve_d = starve_q;
        if (!head_v || head_yumi) begin
            starve_d = '0;
        end else if (starve_q != StarveW'(starve_limit_p)) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign stall_wb_o = ~reset_i & (starve_q == StarveW'(starve_limit_p));

    a_int_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        !(int_wb_yumi_i && !int_wb_v_o));

    a_float_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        !(float_wb_yumi_i && !float_wb_v_o));

endmodule

// File: tb/tb_bsg_vanilla_remote_load_wb.sv
// Scoreboard bench for the remote load writeback buffer.
module tb_bsg_vanilla_remote_load_wb;
    import bsg_vanilla_pkg::*;

    typedef struct {
        logic        fl;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              resp_v_i = 1'b0;
    remote_load_resp_s resp_i = '0;
    logic              resp_ready_o;
    logic              int_wb_v_o, float_wb_v_o, stall_wb_o;
    logic [4:0]        int_wb_addr_o, float_wb_addr_o;
    logic [31:0]       int_wb_data_o, float_wb_data_o;
    logic              int_wb_yumi_i = 1'b0;
    logic              float_wb_yumi_i = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    bsg_vanilla_remote_load_wb #(
        .els_p          (2),
        .starve_limit_p (16)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .resp_v_i        (resp_v_i),
        .resp_i          (resp_i),
        .resp_ready_o    (resp_ready_o),
        .int_wb_v_o      (int_wb_v_o),
        .int_wb_addr_o   (int_wb_addr_o),
        .int_wb_data_o   (int_wb_data_o),
        .int_wb_yumi_i   (int_wb_yumi_i),
        .float_wb_v_o    (float_wb_v_o),
        .float_wb_addr_o (float_wb_addr_o),
        .float_wb_data_o (float_wb_data_o),
        .float_wb_yumi_i (float_wb_yumi_i),
        .stall_wb_o      (stall_wb_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic remote_load_resp_s mk(input logic fl, input logic [4:0] id,
                                             input logic uns, input logic byt, input logic hex,
                                             input logic [1:0] ps, input logic [31:0] d);
        remote_load_resp_s r;
        r.float_wb = fl; r.reg_id = id; r.is_unsigned_op = uns;
        r.is_byte_op = byt; r.is_hex_op = hex; r.part_sel = ps; r.data = d;
        return r;
    endfunction

    function automatic exp_t model(input remote_load_resp_s r);
        exp_t        e;
        logic [31:0] w;
        e.fl = r.float_wb;
        e.addr = r.reg_id;
        if (r.float_wb) begin
            w = r.data;
        end else if (r.is_byte_op) begin
            w = (r.data >> (8 * r.part_sel)) & 32'h0000_00FF;
            if (!r.is_unsigned_op && w[7]) w = w | 32'hFFFF_FF00;
        end else if (r.is_hex_op) begin
            w = (r.data >> (r.part_sel[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (!r.is_unsigned_op && w[15]) w = w | 32'hFFFF_0000;
        end else begin
            w = r.data;
        end
        e.data = w;
        return e;
    endfunction

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        checks++;
        if (int_wb_v_o !== 1'b0 || float_wb_v_o !== 1'b0 || stall_wb_o !== 1'b0
            || resp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got iv=%b fv=%b st=%b rdy=%b want 0 0 0 0",
                     int_wb_v_o, float_wb_v_o, stall_wb_o, resp_ready_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (resp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", resp_ready_o);
        end
    endtask

    task automatic test_byte();
        exp_t e;
        resp_i = mk(1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 2'd3, 32'h80FF_7F01);
        resp_v_i = 1'b1;
        if (resp_ready_o) expq.push_back('{fl: 1'b0, addr: 5'd7, data: 32'hFFFF_FF80});
        tick();
        resp_v_i = 1'b0;
        e = expq.pop_front();
        checks++;
        if (int_wb_v_o !== 1'b1 || float_wb_v_o !== 1'b0 || int_wb_addr_o !== e.addr
            || int_wb_data_o !== e.data) begin
            errors++;
            $display("FAIL byte_signed got iv=%b fv=%b a=%0d d=%h want 1 0 %0d %h",
                     int_wb_v_o, float_wb_v_o, int_wb_addr_o, int_wb_data_o, e.addr, e.data);
        end
        int_wb_yumi_i = int_wb_v_o;
        tick();
        int_wb_yumi_i = 1'b0;
        checks++;
        if (int_wb_v_o !== 1'b0) begin
            errors++;
            $display("FAIL byte_retire got iv=%b want 0", int_wb_v_o);
        end
    endtask

    task automatic test_hex();
        exp_t e;
        resp_v_i = 1'b1;
        resp_i = mk(1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 2'd2, 32'h8001_1234);
        if (resp_ready_o) expq.push_back('{fl: 1'b0, addr: 5'd9, data: 32'h0000_8001});
        tick();
        resp_i = mk(1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 2'd1, 32'h8001_1234);
        if (resp_ready_o) expq.push_back('{fl: 1'b0, addr: 5'd10, data: 32'h0000_1234});
        tick();
        resp_v_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = expq.pop_front();
            checks++;
            if (int_wb_v_o !== 1'b1 || int_wb_addr_o !== e.addr || int_wb_data_o !== e.data) begin
                errors++;
                $display("FAIL hex_unsigned_%0d got iv=%b a=%0d d=%h want 1 %0d %h", i,
                         int_wb_v_o, int_wb_addr_o, int_wb_data_o, e.addr, e.data);
            end
            int_wb_yumi_i = int_wb_v_o;
            tick();
            int_wb_yumi_i = 1'b0;
        end
    endtask

    task automatic test_float();
        exp_t e;
        resp_i = mk(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 32'h3F80_0000);
        resp_v_i = 1'b1;
        if (resp_ready_o) expq.push_back('{fl: 1'b1, addr: 5'd3, data: 32'h3F80_0000});
        tick();
        resp_v_i = 1'b0;
        e = expq.pop_front();
        checks++;
        if (float_wb_v_o !== 1'b1 || int_wb_v_o !== 1'b0 || float_wb_addr_o !== e.addr
            || float_wb_data_o !== e.data) begin
            errors++;
            $display("FAIL float_wb got fv=%b iv=%b a=%0d d=%h want 1 0 %0d %h",
                     float_wb_v_o, int_wb_v_o, float_wb_addr_o, float_wb_data_o, e.addr, e.data);
        end
        float_wb_yumi_i = float_wb_v_o;
        tick();
        float_wb_yumi_i = 1'b0;
    endtask

    task automatic test_full_order();
        exp_t e;
        resp_v_i = 1'b1;
        resp_i = mk(1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'hAAAA_0001);
        if (resp_ready_o) expq.push_back(model(resp_i));
        tick();
        resp_i = mk(1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'hBBBB_0002);
        if (resp_ready_o) expq.push_back(model(resp_i));
        tick();
        resp_i = mk(1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0, 32'hCCCC_0003);
        checks++;
        if (resp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", resp_ready_o);
        end
        for (int i = 0; i < 2; i++) begin
            e = expq.pop_front();
            checks++;
            if (int_wb_v_o !== 1'b1 || int_wb_addr_o !== e.addr || int_wb_data_o !== e.data) begin
                errors++;
                $display("FAIL order_%0d got a=%0d d=%h want %0d %h", i,
                         int_wb_addr_o, int_wb_data_o, e.addr, e.data);
            end
            if (resp_ready_o) expq.push_back(model(resp_i));
            int_wb_yumi_i = int_wb_v_o;
            tick();
            if (i == 0) begin
                checks++;
                if (resp_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_deq got %b want 1", resp_ready_o);
                end
            end
        end
        resp_v_i = 1'b0;
        int_wb_yumi_i = 1'b0;
        checks++;
        if (expq.size() != 1) begin
            errors++;
            $display("FAIL third_accept got queued=%0d want 1", expq.size());
        end else begin
            e = expq.pop_front();
            if (int_wb_v_o !== 1'b1 || int_wb_addr_o !== e.addr || resp_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL third_head got iv=%b a=%0d rdy=%b want 1 %0d 1",
                         int_wb_v_o, int_wb_addr_o, resp_ready_o, e.addr);
            end
        end
        int_wb_yumi_i = int_wb_v_o;
        tick();
        int_wb_yumi_i = 1'b0;
    endtask

    task automatic test_starve();
        resp_i = mk(1'b0, 5'd12, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1234_5678);
        resp_v_i = 1'b1;
        tick();
        resp_v_i = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 15) begin
                checks++;
                if (stall_wb_o !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_early got %b want 0 at cycle 15", stall_wb_o);
                end
            end
        end
        checks++;
        if (stall_wb_o !== 1'b1 || int_wb_v_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_stall got st=%b iv=%b want 1 1 at cycle 16",
                     stall_wb_o, int_wb_v_o);
        end
        int_wb_yumi_i = int_wb_v_o;
        tick();
        int_wb_yumi_i = 1'b0;
        checks++;
        if (stall_wb_o !== 1'b0 || int_wb_v_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_release got st=%b iv=%b want 0 0", stall_wb_o, int_wb_v_o);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        resp_v_i = 1'b1;
        resp_i = mk(1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 32'h5555_5555);
        tick();
        resp_i = mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 2'd0, 32'h6666_6666);
        tick();
        resp_v_i = 1'b0;
        checks++;
        if (resp_ready_o !== 1'b0 || int_wb_v_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill got rdy=%b iv=%b want 0 1", resp_ready_o, int_wb_v_o);
        end
        reset_i = 1'b1;
        tick();
        checks++;
        if (int_wb_v_o !== 1'b0 || float_wb_v_o !== 1'b0 || resp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got iv=%b fv=%b rdy=%b want 0 0 0",
                     int_wb_v_o, float_wb_v_o, resp_ready_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (resp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_release_ready got %b want 1", resp_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (int_wb_v_o !== 1'b0 || float_wb_v_o !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_discard got %0d valid cycles want 0", seen);
        end
        expq.delete();
    endtask

    task automatic test_back_to_back();
        exp_t              e;
        remote_load_resp_s r;
        int                sent = 0;
        int                budget = 600;
        int                mode;
        while ((sent < 30 || expq.size() != 0) && budget > 0) begin
            budget--;
            int_wb_yumi_i = 1'b0;
            float_wb_yumi_i = 1'b0;
            if (int_wb_v_o || float_wb_v_o) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got iv=%b fv=%b want no write",
                             int_wb_v_o, float_wb_v_o);
                end else begin
                    e = expq[0];
                    if (int_wb_v_o !== ~e.fl || float_wb_v_o !== e.fl
                        || (e.fl ? float_wb_addr_o : int_wb_addr_o) !== e.addr
                        || (e.fl ? float_wb_data_o : int_wb_data_o) !== e.data) begin
                        errors++;
                        $display("FAIL b2b_head got iv=%b fv=%b ia=%0d id=%h fa=%0d fd=%h want fl=%b a=%0d d=%h",
                                 int_wb_v_o, float_wb_v_o, int_wb_addr_o, int_wb_data_o,
                                 float_wb_addr_o, float_wb_data_o, e.fl, e.addr, e.data);
                    end
                    if ($urandom_range(0, 2) != 0) begin
                        if (float_wb_v_o) float_wb_yumi_i = 1'b1;
                        else              int_wb_yumi_i = 1'b1;
                        void'(expq.pop_front());
                    end
                end
            end
            resp_v_i = 1'b0;
            if (sent < 30 && $urandom_range(0, 3) != 0) begin
                mode = $urandom_range(0, 3);
                r = mk(mode == 3, 5'($urandom), 1'($urandom), mode == 1, mode == 2,
                       2'($urandom), $urandom);
                resp_i = r;
                resp_v_i = 1'b1;
                if (resp_ready_o) begin
                    expq.push_back(model(r));
                    sent++;
                end
            end
            tick();
        end
        resp_v_i = 1'b0;
        int_wb_yumi_i = 1'b0;
        float_wb_yumi_i = 1'b0;
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL b2b_timeout got sent=%0d pending=%0d want drained", sent, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_hex();
        test_float();
        test_full_order();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
